riscv_dmem: RTL

RISCV_DMEM -- requirements
Module: riscv_dmem

---
 rtl/riscv_dmem_pkg.sv | 13 +
 rtl/riscv_dmem_wbuf.sv | 42 ++++
 rtl/riscv_dmem.sv | 90 +++++++++
 3 files changed

// File: rtl/riscv_dmem_pkg.sv
// rtl/riscv_dmem_pkg.sv - shared sizes and types for the riscv_dmem data memory
package riscv_dmem_pkg;
  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;
  localparam int STAT_W      = 16;

  typedef struct packed {
    logic                   valid;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] data;
  } wbuf_t;
endpackage

// File: rtl/riscv_dmem_wbuf.sv
// rtl/riscv_dmem_wbuf.sv - one-entry posted write buffer with read bypass compare
module riscv_dmem_wbuf
  import riscv_dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              commit_o,
  output logic [ADDR_W-1:0] commit_addr_o,
  output logic [DATA_W-1:0] commit_data_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= wr_en_i;
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en_i) begin
      addr_q <= wr_addr_i;
      data_q <= wr_data_i;
    end
  end

  // A held entry always leaves at the next edge: overwritten by a new store or drained when idle.
  assign commit_o      = valid_q;
  assign commit_addr_o = addr_q;
  assign commit_data_o = data_q;
  assign hit_o         = valid_q && (addr_q == rd_addr_i);
  assign hit_data_o    = data_q;
endmodule

// File: rtl/riscv_dmem.sv
// rtl/riscv_dmem.sv - word data memory with valid map, posted write buffer and zero-latency loads
// Optional load/store counters enabled by RISCV_DMEM_STATS_EN.
module riscv_dmem
  import riscv_dmem_pkg::*;
#(
  parameter  int DEPTH  = DMEM_DEPTH,
  parameter  int DATA_W = DMEM_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              access_err,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] wr_count
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_map_q;
  logic              access_err_q;

  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  riscv_dmem_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (mem_write),
    .wr_addr_i     (addr),
    .wr_data_i     (wdata),
    .rd_addr_i     (addr),
    .commit_o      (commit),
    .commit_addr_o (commit_addr),
    .commit_data_o (commit_data),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  // Array contents are never reset; the valid map alone hides stale words.
  always_ff @(posedge clk) begin
    if (!reset && commit) mem_q[commit_addr] <= commit_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_map_q  <= '0;
      access_err_q <= 1'b0;
    end else begin
      if (commit) valid_map_q[commit_addr] <= 1'b1;
      access_err_q <= mem_read && mem_write;
    end
  end

  always_comb begin
    rdata = '0;
    if (!reset && mem_read) begin
      if (hit)                    rdata = hit_data;
      else if (valid_map_q[addr]) rdata = mem_q[addr];
    end
  end

  assign access_err = access_err_q;

`ifdef RISCV_DMEM_STATS_EN
  logic [STAT_W-1:0] rd_count_q;
  logic [STAT_W-1:0] wr_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (mem_read && rd_count_q != '1)  rd_count_q <= rd_count_q + 1'b1;
      if (mem_write && wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule
